// File: rtl/arbiter_rr4_ctrl_pkg.sv
// Shared constants and types for the four-requester round-robin arbiter.
// The bench reuses these so model and design agree on widths and encodings.
package arbiter_rr4_ctrl_pkg;

  localparam int NUM_REQ          = 4;
  localparam int PTR_W            = 2;
  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int DEFAULT_CNT_W    = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] ptr_onehot(input logic [PTR_W-1:0] p);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arbiter_rr4_ctrl_if.sv
// req/gnt bundle between the requesting agents (master) and the arbiter (slave).
interface arbiter_rr4_ctrl_if;

  logic       req0;
  logic       req1;
  logic       req2;
  logic       req3;
  logic       gnt0;
  logic       gnt1;
  logic       gnt2;
  logic       gnt3;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  modport master (
    output req0, req1, req2, req3,
    input  gnt0, gnt1, gnt2, gnt3, gnt_id, busy, preempt
  );

  modport slave (
    input  req0, req1, req2, req3,
    output gnt0, gnt1, gnt2, gnt3, gnt_id, busy, preempt
  );

endinterface

// File: rtl/arbiter_rr4_ctrl_rr_pick4.sv
// Combinational round-robin picker: first requester after last_ptr, wrapping mod 4.
module rr_pick4
  import arbiter_rr4_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   winner
);

  // rot[k] is the request of the agent k+1 positions after last_ptr.
  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   offset;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    localparam logic [PTR_W-1:0] OFS = PTR_W'(gi + 1);
    logic [PTR_W-1:0] idx;
    assign idx     = last_ptr + OFS;
    assign rot[gi] = req[idx];
  end

  always_comb begin
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = PTR_W'(i);
      end
    end
  end

  assign found  = |rot;
  assign winner = last_ptr + offset + PTR_W'(1);

endmodule

// File: rtl/arbiter_rr4_ctrl.sv
// Four-requester round-robin arbiter with registered grants and an optional hold limit.
// A dead cycle always separates grants; the hold limit forces release with a preempt pulse.
module arbiter_rr4_ctrl
  import arbiter_rr4_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  arbiter_rr4_ctrl_if.slave  bus
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [PTR_W-1:0]   last_ptr_reg, last_ptr_next;
  logic [PTR_W-1:0]   gnt_id_reg, gnt_id_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               busy_reg, busy_next;
  logic               preempt_reg, preempt_next;

  logic [NUM_REQ-1:0] req_vec;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic               owner_req;

  assign req_vec = {bus.req3, bus.req2, bus.req1, bus.req0};

  rr_pick4 u_pick (
    .req      (req_vec),
    .last_ptr (last_ptr_reg),
    .found    (pick_found),
    .winner   (pick_idx)
  );

  // While granted, gnt_id_reg names the owner.
  assign owner_req = req_vec[gnt_id_reg];

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    last_ptr_next = last_ptr_reg;
    gnt_id_next   = gnt_id_reg;
    gnt_next      = gnt_reg;
    busy_next     = busy_reg;
    preempt_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        gnt_next  = '0;
        busy_next = 1'b0;
        if (pick_found) begin
          state_next    = S_GRANT;
          gnt_next      = ptr_onehot(pick_idx);
          gnt_id_next   = pick_idx;
          last_ptr_next = pick_idx;
          busy_next     = 1'b1;
          hold_cnt_next = '0;
        end
      end

      S_GRANT: begin
        if (!owner_req) begin
          state_next = S_IDLE;
          gnt_next   = '0;
          busy_next  = 1'b0;
        end else if (HOLD_EN && (hold_cnt_reg == HOLD_LAST)) begin
          // Owner stays at lowest priority because last_ptr already points at it.
          state_next   = S_IDLE;
          gnt_next     = '0;
          busy_next    = 1'b0;
          preempt_next = 1'b1;
        end else if (hold_cnt_reg != CNT_MAX) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
      last_ptr_reg <= PTR_W'(NUM_REQ - 1);
      gnt_id_reg   <= '0;
      gnt_reg      <= '0;
      busy_reg     <= 1'b0;
      preempt_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      last_ptr_reg <= last_ptr_next;
      gnt_id_reg   <= gnt_id_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
      preempt_reg  <= preempt_next;
    end
  end

  assign bus.gnt0    = gnt_reg[0];
  assign bus.gnt1    = gnt_reg[1];
  assign bus.gnt2    = gnt_reg[2];
  assign bus.gnt3    = gnt_reg[3];
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.busy    = busy_reg;
  assign bus.preempt = preempt_reg;

  a_onehot_gnt : assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_reg));
  a_busy_gnt   : assert property (@(posedge clk) disable iff (!reset) busy_reg == (|gnt_reg));

endmodule
